// File: rtl/gf16_div2_seq_pkg.sv
// Shared GF(2^4) definitions for the divide-by-x engine: field polynomial,
// multiplicative group order and FSM state encodings.
package gf16_div2_seq_pkg;

  localparam logic [3:0]  GF16_POLY_LO = 4'b0011;
  localparam int unsigned GF16_ORDER   = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/gf16_div2_step.sv
// One GF(2^4) inverse-doubling step (a * x^-1), purely combinational.
// Odd operands get the polynomial folded in so the shift-out bit is zero.
module gf16_div2_step
  import gf16_div2_seq_pkg::*;
#(
  parameter logic [3:0] POLY_LO = GF16_POLY_LO
) (
  input  logic [3:0] i_a,
  output logic [3:0] o_q
);

  logic [4:0] w_red;

  assign w_red = i_a[0] ? ({1'b0, i_a} ^ {1'b1, POLY_LO}) : {1'b0, i_a};
  assign o_q   = w_red[4:1];

endmodule

// File: rtl/gf16_div2_seq.sv
// Sequential D_OUT = D_IN * x^-N, one step per clock; DONE lands N+1 cycles after accept.
// GF16_DIV_EARLY_DONE_EN: zero operand or N mod 15 == 0 skips straight to FIN.
module gf16_div2_seq
  import gf16_div2_seq_pkg::*;
#(
  parameter logic [3:0] POLY_LO = GF16_POLY_LO,
  parameter int         CNT_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [3:0]       D_IN,
  input  logic [CNT_W-1:0] N_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [3:0]       D_OUT
);

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_acc, w_acc_nxt, w_step;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [3:0]       r_dout, w_dout_nxt;
  logic             w_skip;

`ifdef GF16_DIV_EARLY_DONE_EN
  assign w_skip = (D_IN == 4'h0) || ((32'(N_IN) % GF16_ORDER) == 32'd0);
`else
  assign w_skip = (N_IN == '0);
`endif

  gf16_div2_step #(.POLY_LO(POLY_LO)) u_step (
    .i_a (r_acc),
    .o_q (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_dout_nxt  = r_dout;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_acc_nxt   = D_IN;
          w_cnt_nxt   = N_IN;
          w_busy_nxt  = 1'b1;
          w_state_nxt = w_skip ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        w_acc_nxt = w_step;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_FIN;
      end
      ST_FIN: begin
        w_dout_nxt  = r_acc;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_acc   <= 4'h0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dout  <= 4'h0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign D_OUT = r_dout;

endmodule
